vproc_div_unit: RTL

VPROC_DIV_UNIT -- requirements
Module: vproc_div_unit

---
 rtl/vproc_pkg.sv | 33 +++
 rtl/vproc_div_iter.sv | 53 +++++
 rtl/vproc_div_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vproc_pkg.sv
// vproc_pkg: shared types and constants for the iterative divider.
`default_nettype none

package vproc_pkg;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vproc_div_iter.sv
// vproc_div_iter: restoring radix-2 shift/subtract datapath, one quotient bit per step.
`default_nettype none

module vproc_div_iter
  import vproc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      divisor_q;
  logic [32:0]      shifted;
  logic [32:0]      diff;

  // The quotient register doubles as the dividend shift source.
  assign shifted = {remainder, quotient[31]};
  assign diff    = shifted - {1'b0, divisor_q};
  assign last    = (cnt == CNT_W'(DIV_ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      divisor_q <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      cnt       <= '0;
      divisor_q <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (!diff[32]) begin
        remainder <= diff[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= shifted[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vproc_div_unit.sv
// vproc_div_unit: 32-bit DIV/DIVU/REM/REMU unit with tag and valid/ready handshakes.
// Optional VPROC_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass CALC/FIX.
`default_nettype none

module vproc_div_unit
  import vproc_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk_i,
  input  logic            sync_rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [31:0]     req_op1_i,
  input  logic [31:0]     req_op2_i,
  input  logic [ID_W-1:0] req_id_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [31:0]     res_o,
  output logic [ID_W-1:0] res_id_o
);

  div_state_e      state;
  div_op_e         req_op;
  div_op_e         op_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     op1_q;
  logic [31:0]     result_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            div0_q;

  logic        accept;
  logic        req_signed;
  logic        op1_neg;
  logic        op2_neg;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] fix_res;
  logic        iter_last;
  logic        early_hit;
  logic [31:0] early_res;

  assign req_op      = div_op_e'(req_op_i);
  assign req_signed  = op_is_signed(req_op);
  assign op1_neg     = req_signed & req_op1_i[31];
  assign op2_neg     = req_signed & req_op2_i[31];
  assign mag1        = op1_neg ? (~req_op1_i + 32'd1) : req_op1_i;
  assign mag2        = op2_neg ? (~req_op2_i + 32'd1) : req_op2_i;
  assign req_ready_o = (state == ST_IDLE);
  assign accept      = req_valid_i & req_ready_o;

  vproc_div_iter u_iter (
    .clk       (clk_i),
    .rst       (sync_rst_i),
    .start     (accept),
    .step      (state == ST_CALC),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (quo),
    .remainder (rem),
    .last      (iter_last)
  );

  assign quo_s = q_neg_q ? (~quo + 32'd1) : quo;
  assign rem_s = r_neg_q ? (~rem + 32'd1) : rem;

  // Signed overflow falls out of the magnitude path naturally; only the
  // divide-by-zero quotient needs overriding because of sign correction.
  always_comb begin
    fix_res = op_is_rem(op_q) ? rem_s : quo_s;
    if (div0_q) begin
      fix_res = op_is_rem(op_q) ? op1_q : 32'hFFFF_FFFF;
    end
  end

`ifdef VPROC_DIV_EARLY_OUT_EN
  logic early_div0;
  logic early_ovf;

  assign early_div0 = (req_op2_i == 32'd0);
  assign early_ovf  = req_signed && (req_op1_i == 32'h8000_0000) &&
                      (req_op2_i == 32'hFFFF_FFFF);
  assign early_hit  = early_div0 | early_ovf;
  assign early_res  = early_div0 ? (op_is_rem(req_op) ? req_op1_i : 32'hFFFF_FFFF)
                                 : (op_is_rem(req_op) ? 32'd0 : 32'h8000_0000);
`else
  assign early_hit = 1'b0;
  assign early_res = 32'd0;
`endif

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state       <= ST_IDLE;
      res_valid_o <= 1'b0;
      res_o       <= '0;
      res_id_o    <= '0;
      op_q        <= DIV;
      id_q        <= '0;
      op1_q       <= '0;
      result_q    <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            id_q    <= req_id_i;
            op1_q   <= req_op1_i;
            q_neg_q <= op1_neg ^ op2_neg;
            r_neg_q <= op1_neg;
            div0_q  <= (req_op2_i == 32'd0);
            if (early_hit) begin
              result_q <= early_res;
              state    <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (iter_last) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q <= fix_res;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle publishes the result; it then holds until taken.
          if (!res_valid_o) begin
            res_valid_o <= 1'b1;
            res_o       <= result_q;
            res_id_o    <= id_q;
          end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
